// File: rtl/compressor_column_resolver.sv
// Serial carry resolver for the 7:3 compressor output stream: accepts one
// (sum, carry, cout) column per handshake, LSB first, and presents the binary total.
module compressor_column_resolver #(
  parameter int RESULT_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sum,
  input  logic                in_carry,
  input  logic                in_cout,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [RESULT_W-1:0] out_result,
  output logic                out_ovf
);

  localparam int COL_W = $clog2(RESULT_W + 1);

  localparam logic [1:0] S_ACCEPT = 2'd0;
  localparam logic [1:0] S_FLUSH  = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [2:0]          pend0_q, pend0_d;
  logic                pend1_q, pend1_d;
  logic [RESULT_W-1:0] result_q, result_d;
  logic                ovf_q, ovf_d;

  logic       proc;
  logic       s, c, k;
  logic [2:0] v;
  logic       bit_v;

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    pend0_d  = pend0_q;
    pend1_d  = pend1_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    proc     = 1'b0;
    s        = 1'b0;
    c        = 1'b0;
    k        = 1'b0;

    case (state_q)
      S_ACCEPT: begin
        if (in_valid) begin
          proc = 1'b1;
          s    = in_sum;
          c    = in_carry;
          k    = in_cout;
          if (in_last) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (pend0_q == 3'd0 && !pend1_q) state_d = S_DONE;
        else                             proc    = 1'b1;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d  = S_ACCEPT;
          col_d    = '0;
          pend0_d  = '0;
          pend1_d  = 1'b0;
          result_d = '0;
          ovf_d    = 1'b0;
        end
      end
      default: state_d = S_ACCEPT;
    endcase

    // pend0 never exceeds 4, so v fits in 3 bits
    v     = pend0_q + {2'b00, s};
    bit_v = v[0];

    if (proc) begin
      pend0_d = {2'b00, pend1_q} + {2'b00, c} + {1'b0, v[2:1]};
      pend1_d = k;
      if (col_q < COL_W'(RESULT_W)) begin
        for (int i = 0; i < RESULT_W; i++)
          if (col_q == COL_W'(i)) result_d[i] = bit_v;
        col_d = col_q + 1'b1;
      end else if (bit_v) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_ACCEPT;
      col_q    <= '0;
      pend0_q  <= '0;
      pend1_q  <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      pend0_q  <= pend0_d;
      pend1_q  <= pend1_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready   = (state_q == S_ACCEPT);
  assign out_valid  = (state_q == S_DONE);
  assign out_result = out_valid ? result_q : '0;
  assign out_ovf    = out_valid & ovf_q;

endmodule

// File: tb/tb_compressor_column_resolver.sv
// Scoreboard bench: a 16-bit and a 4-bit resolver share the same stimulus;
// the monitor checks each result handshake against queued hand-computed totals.
module tb_compressor_column_resolver;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0, in_sum = 1'b0, in_carry = 1'b0, in_cout = 1'b0, in_last = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready16, out_valid16, out_ovf16;
  logic in_ready4, out_valid4, out_ovf4;
  logic [15:0] out_result16;
  logic [3:0]  out_result4;

  always #5 clk = ~clk;

  compressor_column_resolver #(.RESULT_W(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready16),
    .in_sum(in_sum), .in_carry(in_carry), .in_cout(in_cout), .in_last(in_last),
    .out_valid(out_valid16), .out_ready(out_ready), .out_result(out_result16),
    .out_ovf(out_ovf16));

  compressor_column_resolver #(.RESULT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_sum(in_sum), .in_carry(in_carry), .in_cout(in_cout), .in_last(in_last),
    .out_valid(out_valid4), .out_ready(out_ready), .out_result(out_result4),
    .out_ovf(out_ovf4));

  typedef struct {
    logic [15:0] r16;
    logic        o16;
    logic [3:0]  r4;
    logic        o4;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Monitor: compare on each result handshake
  always @(negedge clk) begin
    if (out_valid16 && out_ready) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("result16", 32'(out_result16), 32'(e.r16));
        chk("ovf16",    32'(out_ovf16),    32'(e.o16));
        chk("valid4",   32'(out_valid4),   32'd1);
        chk("result4",  32'(out_result4),  32'(e.r4));
        chk("ovf4",     32'(out_ovf4),     32'(e.o4));
      end
    end
  end

  task automatic expect_res(input logic [15:0] r16, input logic o16,
                            input logic [3:0] r4, input logic o4);
    exp_t e;
    e.r16 = r16; e.o16 = o16; e.r4 = r4; e.o4 = o4;
    exp_q.push_back(e);
  endtask

  // Present one column; returns #1 after the accepting edge
  task automatic send_col(input logic s, input logic c, input logic k, input logic last);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_sum = s; in_carry = c; in_cout = k; in_last = last;
    n = 0;
    while (!in_ready16 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("in_ready_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_sum = 1'b0; in_carry = 1'b0; in_cout = 1'b0; in_last = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid16) begin
        cyc = i;
        break;
      end
    end
    if (cyc == 0) chk("out_valid_timeout", 32'd1, 32'd0);
  endtask

  task automatic release_res();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("back_in_ready", 32'(in_ready16), 32'd1);
    chk("back_out_valid", 32'(out_valid16), 32'd0);
  endtask

  initial begin
    int cyc;

    #1;
    chk("rst_in_ready",  32'(in_ready16),   32'd1);
    chk("rst_out_valid", 32'(out_valid16),  32'd0);
    chk("rst_result",    32'(out_result16), 32'd0);
    chk("rst_ovf",       32'(out_ovf16),    32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // 1: single column (1,1,1) -> 7, latency 3
    expect_res(16'd7, 1'b0, 4'd7, 1'b0);
    send_col(1, 1, 1, 1);
    chk("t1_in_ready_flush", 32'(in_ready16), 32'd0);
    wait_done(cyc);
    chk("t1_latency", 32'(cyc), 32'd3);
    release_res();

    // 2: two columns -> 21 (4-bit: 5, ovf)
    expect_res(16'd21, 1'b0, 4'd5, 1'b1);
    send_col(1, 1, 1, 0);
    send_col(1, 1, 1, 1);
    wait_done(cyc);
    release_res();

    // 3: four columns -> 105 (4-bit: 9, ovf)
    expect_res(16'd105, 1'b0, 4'd9, 1'b1);
    for (int i = 0; i < 4; i++) send_col(1, 1, 1, (i == 3));
    wait_done(cyc);
    release_res();

    // 4: hold out_ready low in DONE
    expect_res(16'd7, 1'b0, 4'd7, 1'b0);
    send_col(1, 1, 1, 1);
    wait_done(cyc);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid",    32'(out_valid16),  32'd1);
      chk("t4_hold_result",   32'(out_result16), 32'd7);
      chk("t4_hold_ovf",      32'(out_ovf16),    32'd0);
      chk("t4_hold_in_ready", 32'(in_ready16),   32'd0);
      @(posedge clk);
      #1;
    end
    release_res();
    chk("t4_result_cleared", 32'(out_result16), 32'd0);

    // 5: gaps between columns -> 21
    expect_res(16'd21, 1'b0, 4'd5, 1'b1);
    send_col(1, 0, 0, 0);
    gap(3);
    send_col(0, 1, 0, 0);
    gap(2);
    send_col(0, 0, 1, 1);
    wait_done(cyc);
    release_res();

    // 6: reset mid-FLUSH discards the operand
    send_col(1, 1, 1, 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_in_ready",  32'(in_ready16),   32'd1);
    chk("t6_rst_out_valid", 32'(out_valid16),  32'd0);
    chk("t6_rst_result",    32'(out_result16), 32'd0);
    chk("t6_rst_ovf",       32'(out_ovf16),    32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    expect_res(16'd2, 1'b0, 4'd2, 1'b0);
    send_col(0, 1, 0, 1);
    wait_done(cyc);
    release_res();

    gap(2);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
